// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default width
// and the signed-overflow rule used when the last bit is produced.
package serial_subtractor_pkg;

  localparam int SUB_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Overflow when operand signs differ and the result sign differs from the minuend.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic d_msb);
    return (a_msb ^ b_msb) & (d_msb ^ a_msb);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full-subtractor cell: d = x - y - bi, with borrow-out bo.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - borrow_in, one bit per clock,
// LSB first, with valid/ready handshakes on both sides.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             borrow_out_q, borrow_out_d;
  logic             ovf_q, ovf_d;

  logic fs_d, fs_bo;

  full_subtractor u_cell (
    .x  (a_sr_q[0]),
    .y  (b_sr_q[0]),
    .bi (borrow_q),
    .d  (fs_d),
    .bo (fs_bo)
  );

  always_comb begin
    // NOTE: every next-state signal starts from its current value, so no branch can infer a latch.
    state_d      = state_q;
    a_sr_d       = a_sr_q;
    b_sr_d       = b_sr_q;
    res_d        = res_q;
    borrow_d     = borrow_q;
    cnt_d        = cnt_q;
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    borrow_out_d = borrow_out_q;
    ovf_d        = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sr_d   = a;
          b_sr_d   = b;
          borrow_d = borrow_in;
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
          cnt_d    = '0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Result enters from the MSB side so that after WIDTH bits it is aligned.
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_d    = {fs_d, res_q[WIDTH-1:1]};
        borrow_d = fs_bo;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          borrow_out_d = fs_bo;
          ovf_d        = signed_ovf(a_msb_q, b_msb_q, fs_d);
          state_d      = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: datapath registers are reset as well, so diff/borrow_out/ovf read 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      a_sr_q       <= '0;
      b_sr_q       <= '0;
      res_q        <= '0;
      borrow_q     <= 1'b0;
      cnt_q        <= '0;
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      borrow_out_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
      state_q      <= state_d;
      a_sr_q       <= a_sr_d;
      b_sr_q       <= b_sr_d;
      res_q        <= res_d;
      borrow_q     <= borrow_d;
      cnt_q        <= cnt_d;
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      borrow_out_q <= borrow_out_d;
      ovf_q        <= ovf_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign diff       = res_q;
  assign borrow_out = borrow_out_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8) and its full_subtractor cell.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       borrow_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       borrow_out;
  logic       ovf;

  logic fs_x, fs_y, fs_bi, fs_d, fs_bo;

  int vectors    = 0;
  int miscompares = 0;

  // Truth tables indexed by {x, y, bi}.
  logic [7:0] d_tab  = 8'b1001_0110;
  logic [7:0] bo_tab = 8'b1000_1110;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .ovf        (ovf)
  );

  full_subtractor u_fs (
    .x  (fs_x),
    .y  (fs_y),
    .bi (fs_bi),
    .d  (fs_d),
    .bo (fs_bo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic bi);
    int n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    check("in_ready_before_accept", 32'(in_ready), 1);
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    borrow_in = bi;
    tick();
    in_valid  = 1'b0;
    a         = ~av;
    b         = ~bv;
    borrow_in = ~bi;
    check("in_ready_after_accept", 32'(in_ready), 0);
  endtask

  task automatic wait_done(input int already);
    int lat = already;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 8);
  endtask

  task automatic check_result(input logic [7:0] ed, input logic eb, input logic eo);
    check("diff", 32'(diff), 32'(ed));
    check("borrow_out", 32'(borrow_out), 32'(eb));
    check("ovf", 32'(ovf), 32'(eo));
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("in_ready_after_release", 32'(in_ready), 1);
    check("out_valid_after_release", 32'(out_valid), 0);
  endtask

  task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                       input logic [7:0] ed, input logic eb, input logic eo);
    start_op(av, bv, bi);
    wait_done(0);
    check_result(ed, eb, eo);
    finish_op();
  endtask

  initial begin
    logic [7:0] av, bv;
    logic       bi_r;
    logic [8:0] full;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    borrow_in = 1'b0;
    fs_x      = 1'b0;
    fs_y      = 1'b0;
    fs_bi     = 1'b0;

    // Cell truth table
    for (int i = 0; i < 8; i++) begin
      {fs_x, fs_y, fs_bi} = 3'(i);
      #1;
      check("fs_d", 32'(fs_d), 32'(d_tab[i]));
      check("fs_bo", 32'(fs_bo), 32'(bo_tab[i]));
    end

    // Reset state
    #20;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_diff", 32'(diff), 0);
    check("rst_borrow_out", 32'(borrow_out), 0);
    check("rst_ovf", 32'(ovf), 0);
    rst_n = 1'b1;
    tick();

    // Basic, borrow and overflow cases
    do_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    do_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    do_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    do_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    do_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

    // Backpressure in DONE with ignored input requests
    start_op(8'h5A, 8'h21, 1'b0);
    wait_done(0);
    check_result(8'h39, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a        = 8'h11;
      b        = 8'h22;
      tick();
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_diff", 32'(diff), 'h39);
      check("bp_in_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    finish_op();
    tick();
    tick();
    check("bp_not_remembered", 32'(in_ready), 1);

    // Requests during SHIFT are ignored
    start_op(8'h20, 8'h07, 1'b1);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a        = 8'hAA;
      b        = 8'h55;
      tick();
      check("shift_in_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    wait_done(5);
    check_result(8'h18, 1'b0, 1'b0);
    finish_op();

    // Leave borrow_out/ovf set so the asynchronous clear is visible
    do_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

    // Asynchronous reset after 4 bit-edges
    start_op(8'h33, 8'h11, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 1);
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_diff", 32'(diff), 0);
    check("arst_borrow_out", 32'(borrow_out), 0);
    check("arst_ovf", 32'(ovf), 0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("arst_no_partial", 32'(out_valid), 0);
    do_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);

    // Random sweep against an arithmetic reference
    for (int i = 0; i < 100; i++) begin
      av   = 8'($urandom);
      bv   = 8'($urandom);
      bi_r = 1'($urandom);
      full = {1'b0, av} - {1'b0, bv} - 9'(bi_r);
      do_op(av, bv, bi_r, full[7:0], full[8], (av[7] ^ bv[7]) & (full[7] ^ av[7]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
